// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: port geometry, packet field positions, scheduler state encoding.
package xbar_pkg;
  localparam int NPORTS    = 4;
  localparam int PORT_W    = 2;
  localparam int VALID_BIT = 14;
  localparam int DEST_HI   = 12;
  localparam int DEST_LO   = 11;
  localparam int SRC_HI    = 9;
  localparam int SRC_LO    = 8;
  localparam int PLD_HI    = 7;
  localparam int PLD_LO    = 0;

  typedef enum logic {
    SCHED_IDLE = 1'b0,
    SCHED_HOLD = 1'b1
  } sched_state_e;

  function automatic logic [PORT_W-1:0] next_port(input logic [PORT_W-1:0] p);
    return p + 2'd1;
  endfunction
endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way rotate-priority picker: first set req bit at or above ptr, wrapping mod 4.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       hit,
  output logic [1:0] idx
);
  logic [1:0] cur;

  // Walk from the farthest offset down so the nearest match to ptr wins last.
  always_comb begin
    hit = 1'b0;
    idx = ptr;
    cur = '0;
    for (int k = 3; k >= 0; k--) begin
      cur = ptr + 2'(k);
      if (req[cur]) begin
        hit = 1'b1;
        idx = cur;
      end
    end
  end
endmodule

// File: rtl/xbar_rr_scheduler.sv
// Round-robin per-output burst scheduler for the 4x4 crossbar.
// Optional macro XBAR_SCHED_STATS_EN adds per-output saturating conflict counters.
module xbar_rr_scheduler
  import xbar_pkg::*;
#(
  parameter int BURST = 4,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  in_valid,
  input  logic [7:0]  in_dest,
  output logic [3:0]  in_ready,
  output logic [3:0]  out_en,
  output logic [7:0]  out_sel,
  output logic [3:0]  dbg_state
`ifdef XBAR_SCHED_STATS_EN
  ,
  output logic [31:0] conflict_cnt
`endif
);
  // Handshake: input i transfers a beat on a cycle where in_valid[i] && in_ready[i];
  // in_ready never depends on in_ready, only on in_valid and registered grant state,
  // and a source must hold in_valid and in_dest steady until it sees the beat accepted.

  sched_state_e     state_q [NPORTS];
  logic [1:0]       sel_q   [NPORTS];
  logic [1:0]       ptr_q   [NPORTS];
  logic [CNT_W-1:0] cnt_q   [NPORTS];
  logic [3:0]       en_q;
  logic [3:0]       busy;
  logic [15:0]      cand;
  logic [3:0]       hit;
  logic [7:0]       pick_idx;

  always_comb begin
    busy     = '0;
    in_ready = '0;
    for (int o = 0; o < NPORTS; o++) begin
      if (en_q[o]) begin
        busy[sel_q[o]]     = 1'b1;
        in_ready[sel_q[o]] = in_valid[sel_q[o]];
      end
    end
  end

  // Inputs already held by some output are masked so two idle outputs never share one.
  always_comb begin
    cand = '0;
    for (int o = 0; o < NPORTS; o++) begin
      for (int i = 0; i < NPORTS; i++) begin
        cand[4*o+i] = in_valid[i] && (in_dest[2*i +: 2] == 2'(o)) && !busy[i];
      end
    end
  end

  for (genvar g = 0; g < NPORTS; g++) begin : g_pick
    rr_pick4 u_pick (
      .req (cand[4*g +: 4]),
      .ptr (ptr_q[g]),
      .hit (hit[g]),
      .idx (pick_idx[2*g +: 2])
    );
  end

`ifdef XBAR_SCHED_STATS_EN
  logic [31:0] cc_q;
  assign conflict_cnt = cc_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q <= '0;
      for (int o = 0; o < NPORTS; o++) begin
        state_q[o] <= SCHED_IDLE;
        sel_q[o]   <= '0;
        ptr_q[o]   <= '0;
        cnt_q[o]   <= '0;
      end
`ifdef XBAR_SCHED_STATS_EN
      cc_q <= '0;
`endif
    end else begin
      for (int o = 0; o < NPORTS; o++) begin
        case (state_q[o])
          SCHED_IDLE: begin
            if (hit[o]) begin
              state_q[o] <= SCHED_HOLD;
              sel_q[o]   <= pick_idx[2*o +: 2];
              en_q[o]    <= 1'b1;
              cnt_q[o]   <= '0;
`ifdef XBAR_SCHED_STATS_EN
              if ($countones(cand[4*o +: 4]) > 1 && cc_q[8*o +: 8] != 8'hFF)
                cc_q[8*o +: 8] <= cc_q[8*o +: 8] + 8'd1;
`endif
            end
          end
          SCHED_HOLD: begin
            // Early release when the source goes quiet, normal release on the last beat.
            if (!in_valid[sel_q[o]] || cnt_q[o] == CNT_W'(BURST - 1)) begin
              state_q[o] <= SCHED_IDLE;
              en_q[o]    <= 1'b0;
              ptr_q[o]   <= next_port(sel_q[o]);
            end else begin
              cnt_q[o] <= cnt_q[o] + 1'b1;
            end
          end
          default: state_q[o] <= SCHED_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    out_en    = en_q;
    out_sel   = '0;
    dbg_state = '0;
    for (int o = 0; o < NPORTS; o++) begin
      out_sel[2*o +: 2] = sel_q[o];
      dbg_state[o]      = state_q[o];
    end
  end
endmodule

// File: tb/tb_xbar_rr_scheduler.sv
// Self-checking bench for xbar_rr_scheduler: directed scenarios plus random traffic vs a reference model.
module tb_xbar_rr_scheduler;
  localparam int BURST = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [7:0]  in_dest;
  logic [3:0]  in_ready;
  logic [3:0]  out_en;
  logic [7:0]  out_sel;
  logic [3:0]  dbg_state;
  logic [31:0] conflict_cnt;

  always #5 clk = ~clk;

  xbar_rr_scheduler #(.BURST(BURST), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_dest   (in_dest),
    .in_ready  (in_ready),
    .out_en    (out_en),
    .out_sel   (out_sel),
    .dbg_state (dbg_state)
`ifdef XBAR_SCHED_STATS_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

`ifndef XBAR_SCHED_STATS_EN
  assign conflict_cnt = '0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: which input each output is serving (-1 = free), beats done, next-start port.
  int hold_in [4];
  int beats   [4];
  int ptr_m   [4];
  int last_sel[4];
  int ccnt    [4];

  logic [3:0]  prev_valid;
  logic [7:0]  prev_dest;
  logic [3:0]  obs_en, obs_ready;
  logic [7:0]  obs_sel;
  logic [31:0] obs_cc;
  logic [1:0]  exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int o = 0; o < 4; o++) begin
      hold_in[o] = -1; beats[o] = 0; ptr_m[o] = 0; last_sel[o] = 0; ccnt[o] = 0;
    end
  endtask

  task automatic model_update(input logic r, input logic [3:0] v, input logic [7:0] d);
    int held[4];
    int ncand, win, i, h;
    if (r) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 4; k++) held[k] = 0;
    for (int o = 0; o < 4; o++) if (hold_in[o] >= 0) held[hold_in[o]] = 1;
    for (int o = 0; o < 4; o++) begin
      if (hold_in[o] >= 0) begin
        h = hold_in[o];
        if (v[h]) beats[o]++;
        if (!v[h] || beats[o] == BURST) begin
          hold_in[o] = -1;
          ptr_m[o]   = (h + 1) % 4;
        end
      end else begin
        ncand = 0;
        win   = -1;
        for (int k = 0; k < 4; k++) begin
          i = (ptr_m[o] + k) % 4;
          if (v[i] && int'(d[2*i +: 2]) == o && held[i] == 0) begin
            ncand++;
            if (win < 0) win = i;
          end
        end
        if (win >= 0) begin
          hold_in[o]  = win;
          beats[o]    = 0;
          last_sel[o] = win;
          if (ncand >= 2 && ccnt[o] < 255) ccnt[o]++;
        end
      end
    end
  endtask

  // One clock cycle: drive at negedge, compare against the model, then advance the model.
  task automatic step(input logic r, input logic [3:0] v, input logic [7:0] d);
    logic [3:0]  exp_en, exp_ready;
    logic [7:0]  exp_sel;
    logic [31:0] exp_cc;
    @(negedge clk);
    rst = r; in_valid = v; in_dest = d;
    for (int i = 0; i < 4; i++)
      if (prev_valid[i] && v[i]) check("dest_stable", 32'(d[2*i +: 2]), 32'(prev_dest[2*i +: 2]));
    prev_valid = v;
    prev_dest  = d;
    #1;
    exp_en = '0; exp_ready = '0; exp_sel = '0; exp_cc = '0;
    for (int o = 0; o < 4; o++) begin
      exp_en[o]          = (hold_in[o] >= 0);
      exp_sel[2*o +: 2]  = 2'(last_sel[o]);
      exp_cc[8*o +: 8]   = 8'(ccnt[o]);
      if (hold_in[o] >= 0 && v[hold_in[o]]) exp_ready[hold_in[o]] = 1'b1;
    end
    obs_en = out_en; obs_sel = out_sel; obs_ready = in_ready; obs_cc = conflict_cnt;
    check("out_en", 32'(out_en), 32'(exp_en));
    check("out_sel", 32'(out_sel), 32'(exp_sel));
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("dbg_state", 32'(dbg_state), 32'(exp_en));
`ifdef XBAR_SCHED_STATS_EN
    check("conflict_cnt", conflict_cnt, exp_cc);
`endif
    @(posedge clk);
    model_update(r, v, d);
  endtask

  initial begin
    int rdy_cnt, grants;
    logic prev_en1;
    logic [3:0] cur_v;
    logic [7:0] cur_d;
    logic       cur_r;

    rst = 1'b1; in_valid = '0; in_dest = '0;
    prev_valid = '0; prev_dest = '0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset held with all requests up; first grant one cycle after release.
    step(1'b1, 4'hF, 8'h1B);
    check("rst_en", 32'(obs_en), 32'h0);
    check("rst_ready", 32'(obs_ready), 32'h0);
    step(1'b1, 4'hF, 8'h1B);
    step(1'b0, 4'hF, 8'h1B);
    check("first_cycle_en", 32'(obs_en), 32'h0);
    step(1'b0, 4'hF, 8'h1B);
    check("first_grant_en", 32'(obs_en), 32'hF);
    repeat (3) step(1'b0, 4'h0, 8'h00);

    // Single request: input 0 to output 2, four beats then one idle cycle.
    rdy_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 4'b0001, 8'h02);
      rdy_cnt += int'(obs_ready[0]);
      if (k == 1) begin
        check("single_en2", 32'(obs_en[2]), 32'h1);
        check("single_sel2", 32'(obs_sel[5:4]), 32'h0);
      end
    end
    check("single_beats", 32'(rdy_cnt), 32'd4);
    check("single_gap_en2", 32'(obs_en[2]), 32'h0);
    repeat (2) step(1'b0, 4'h0, 8'h00);

    // Conflict: inputs 0,1,3 all to output 1; order 0,1,3,0 with the pointer wrapping.
    step(1'b1, 4'h0, 8'h00);
    step(1'b0, 4'h0, 8'h00);
    exp_q = {2'd0, 2'd1, 2'd3, 2'd0};
    grants = 0;
    prev_en1 = 1'b0;
    for (int k = 0; k < 22; k++) begin
      step(1'b0, 4'b1011, 8'h45);
      if (obs_en[1] && !prev_en1 && exp_q.size() > 0) begin
        check("grant_order", 32'(obs_sel[3:2]), 32'(exp_q.pop_front()));
        grants++;
`ifdef XBAR_SCHED_STATS_EN
        if (grants == 4) check("conflict_after4", 32'(obs_cc[15:8]), 32'd4);
`endif
      end
      prev_en1 = obs_en[1];
    end
    check("grant_count", 32'(grants), 32'd4);
    repeat (2) step(1'b0, 4'h0, 8'h00);

    // Parallel: every input to a distinct output, all granted together.
    step(1'b0, 4'hF, 8'h1B);
    step(1'b0, 4'hF, 8'h1B);
    check("par_en", 32'(obs_en), 32'hF);
    check("par_sel", 32'(obs_sel), 32'h1B);
    repeat (2) step(1'b0, 4'h0, 8'h00);

    // Early release: input 2 to output 0 quits after two beats; pointer moves to 3.
    rdy_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'b0100, 8'h00);
      rdy_cnt += int'(obs_ready[2]);
    end
    check("early_beats", 32'(rdy_cnt), 32'd2);
    step(1'b0, 4'h0, 8'h00);
    step(1'b0, 4'h0, 8'h00);
    check("early_en0", 32'(obs_en[0]), 32'h0);
    step(1'b0, 4'hF, 8'h00);
    step(1'b0, 4'hF, 8'h00);
    check("early_ptr3", 32'(obs_sel[1:0]), 32'd3);
    repeat (2) step(1'b0, 4'h0, 8'h00);

    // Reset mid-burst: input 2 on output 3, reset during beat 2; pointer back to 0.
    step(1'b0, 4'b0100, 8'h30);
    step(1'b0, 4'b0100, 8'h30);
    step(1'b1, 4'b0100, 8'h30);
    step(1'b0, 4'h0, 8'h30);
    check("midrst_en", 32'(obs_en), 32'h0);
    step(1'b0, 4'b1110, 8'hFC);
    step(1'b0, 4'b1110, 8'hFC);
    check("midrst_ptr0", 32'(obs_sel[7:6]), 32'd1);
    check("midrst_en3", 32'(obs_en[3]), 32'h1);
    step(1'b0, 4'h0, 8'h00);

    // Random traffic with stable destinations while requesting and rare resets.
    cur_v = '0;
    cur_d = '0;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_v[i]) begin
          if ($urandom_range(0, 5) == 0) cur_v[i] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          cur_v[i] = 1'b1;
          cur_d[2*i +: 2] = 2'($urandom_range(0, 3));
        end
      end
      cur_r = ($urandom_range(0, 299) == 0);
      step(cur_r, cur_v, cur_d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
